eth_mdio_master: RTL and testbench
==================================

Name: eth_mdio_master

Overview:
- Avalon-MM slave that runs complete IEEE 802.3 clause-22 MDIO management frames to the Ethernet PHY.
- Replaces bit-banged PIO control of the PHY management pins with a hardware serial engine.
- The CPU writes PHY address, register address, opcode and write data, then polls status or takes an interrupt.
- Drives MDC and a tristate MDIO; the pad-level tristate buffer sits in the top level.

Parameters:
- CLK_DIV, 10: clk cycles per MDC half-period. Minimum 2.
- PRE_LEN, 32: preamble length in bits (all ones). Range 1..32.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register select.
- chipselect  in  1  Avalon slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data. Combinational, zero wait states; unused bits read 0.
- mdc  out  1  management clock to PHY.
- mdio_o  out  1  MDIO output value.
- mdio_oe  out  1  MDIO output enable (1 = drive).
- mdio_i  in  1  MDIO pad input.
- irq  out  1  interrupt (see Optional Feature).

Behaviour:
- Register map. A write occurs when chipselect=1 and write_n=0.
  - 0 CMD (write-only, reads 0): [4:0] regad, [9:5] phyad, [10] op (1=read, 0=write), [11] start.
  - 1 WDATA (r/w, [15:0]): can be written at any time. The frame uses the copy latched at start.
  - 2 RDATA (read-only, [15:0]): updated only when a read frame completes.
  - 3 STATUS: [0] busy (ro); [1] done (sticky, write 1 to clear); [2] irq_en (r/w).
- Reset values: mdc=0, mdio_o=1, mdio_oe=0, busy=0, done=0, irq_en=0, RDATA=0, WDATA=0, irq=0.
- A CMD write with start=1 while busy=0 is accepted. A start while busy=1 is ignored completely, including regad, phyad and op.
- The cycle after acceptance: busy=1, done cleared, mdio_oe=1, mdio_o=first preamble bit, mdc=0, div_cnt=0.
- State machine: IDLE -> PRE -> FRAME -> IDLE.
  - PRE sends PRE_LEN ones.
  - FRAME sends 32 bits: ST=01, OP (01 write / 10 read), PHYAD[4:0] MSB first, REGAD[4:0] MSB first, TA, DATA[15:0] MSB first.
- Divider: div_cnt counts 0..CLK_DIV-1. A tick occurs at CLK_DIV-1, and each tick toggles mdc.
- Rising mdc tick (0->1): if in the read data phase, shift mdio_i into the capture register.
- Falling mdc tick (1->0): advance to the next bit and update mdio_o/mdio_oe. Outputs are stable a full half-period before each rising edge.
- Write frame: TA driven as 1,0; mdio_oe=1 for the whole frame.
- Read frame: mdio_oe drops to 0 at the falling tick that starts TA bit 1. It stays 0 through the last data bit. mdio_i is not sampled during TA.
- Completion: at the falling tick after the last data bit:
  - busy=0, done=1, mdio_oe=0, mdio_o=1, mdc stays 0.
  - For a read, RDATA loads the capture register in the same cycle.
- Frame duration: (PRE_LEN+32)*2*CLK_DIV clk cycles from the first busy cycle to the last busy cycle inclusive.
- A done write-1-clear in the same cycle that done is being set: the set wins.
- Reset asserted mid-frame: all state returns to reset values immediately (async). mdio_oe releases with no further edges. The partial RDATA capture is discarded.
- Address 0 reads return 0.

Optional Feature:
- Macro ETH_MDIO_IRQ_EN.
- Defined: irq = done & irq_en, registered (asserts 1 cycle after done sets) and level-held until done is cleared.
- Not defined: irq tied to 0, STATUS[2] reads 0, and writes to it are ignored.

Test Plan:
- Write frame, CLK_DIV=2, PRE_LEN=32: WDATA=0x1140, CMD=0x820 (phyad=1, regad=0, op=0, start). Bits captured on mdc rising edges must be 32 ones then 0101_00001_00000_10_0001000101000000. busy must be high for exactly 256 cycles, then done=1.
- Read frame: CMD=0xFE2 (phyad=0x1F, regad=2, op=1, start) with a PHY model driving 0x0022 after TA. mdio_oe must be 0 from TA onward. RDATA must read 0x0022 and STATUS must read 0x2.
- Start while busy: issue a second CMD 10 cycles into a frame. The serial stream must be unchanged, and exactly one done must occur at the original time.
- Done clear: write STATUS=0x2. STATUS[1] must read 0 next cycle. A clear issued on the completion cycle must leave done=1.
- Reset mid-frame: deassert reset_n during the PHYAD bits. mdc=0, mdio_oe=0, busy=0 and RDATA=0 must hold immediately. A new frame afterwards must complete normally.
- With ETH_MDIO_IRQ_EN, irq_en=1: irq must rise 1 cycle after done and fall 1 cycle after the done clear. Without the macro, irq must stay 0 throughout.

Source files
------------

// File: rtl/eth_mdio_master.sv
// eth_mdio_master: Avalon-MM slave driving IEEE 802.3 clause-22 MDIO frames (MDC + tristate MDIO).
// Define ETH_MDIO_IRQ_EN to enable the registered done interrupt and the STATUS[2] irq_en bit.
module eth_mdio_master #(
    parameter int CLK_DIV = 10,
    parameter int PRE_LEN = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i,
    output logic        irq
);
    localparam int DW = $clog2(CLK_DIV);

    typedef enum logic [1:0] {IDLE, PRE, FRAME} state_t;
    state_t state, state_next;

    logic [DW-1:0] div_cnt;
    logic [4:0]    bit_cnt;
    logic [31:0]   shreg;
    logic          op_rd;
    logic [15:0]   cap;
    logic [15:0]   rdata;
    logic [15:0]   wdata;
    logic          done;
    logic          irq_en;
    logic          wr, busy, accept, tick, rise, fall, last_bit, finish;
    logic          unused_wdata_hi;

    assign unused_wdata_hi = ^writedata[31:16];

    always_comb begin
        wr         = chipselect & ~write_n;
        busy       = (state != IDLE);
        accept     = wr && (address == 2'd0) && writedata[11] && !busy;
        tick       = busy && (div_cnt == DW'(CLK_DIV - 1));
        rise       = tick & ~mdc;
        fall       = tick & mdc;
        last_bit   = (state == PRE) ? (bit_cnt == 5'(PRE_LEN - 1)) : (bit_cnt == 5'd31);
        finish     = fall && last_bit && (state == FRAME);
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = PRE;
            PRE:     if (fall && last_bit) state_next = FRAME;
            FRAME:   if (fall && last_bit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
            op_rd   <= 1'b0;
            cap     <= '0;
            rdata   <= '0;
            wdata   <= '0;
            done    <= 1'b0;
            mdc     <= 1'b0;
            mdio_o  <= 1'b1;
            mdio_oe <= 1'b0;
        end else begin
            if (wr && address == 2'd1) wdata <= writedata[15:0];

            if (finish)                                  done <= 1'b1;
            else if (accept)                             done <= 1'b0;
            else if (wr && address == 2'd3 && writedata[1]) done <= 1'b0;

            if (accept) begin
                div_cnt <= '0;
                bit_cnt <= '0;
                mdc     <= 1'b0;
                mdio_o  <= 1'b1;
                mdio_oe <= 1'b1;
                op_rd   <= writedata[10];
                shreg   <= {2'b01, (writedata[10] ? 2'b10 : 2'b01), writedata[9:5], writedata[4:0],
                            2'b10, (writedata[10] ? 16'h0000 : wdata)};
            end else if (busy) begin
                div_cnt <= tick ? '0 : div_cnt + 1'b1;
                if (tick) mdc <= ~mdc;
                // PHY drives read data bits 16..31; it is sampled as MDC rises
                if (rise && state == FRAME && op_rd && bit_cnt >= 5'd16)
                    cap <= {cap[14:0], mdio_i};
                if (fall) begin
                    if (finish) begin
                        mdio_o  <= 1'b1;
                        mdio_oe <= 1'b0;
                        if (op_rd) rdata <= cap;
                    end else if (state == PRE && last_bit) begin
                        bit_cnt <= '0;
                        mdio_o  <= shreg[31];
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (state == FRAME) begin
                            mdio_o <= shreg[30];
                            shreg  <= {shreg[30:0], 1'b0};
                            if (op_rd && bit_cnt == 5'd13) mdio_oe <= 1'b0;
                        end
                    end
                end
            end
        end
    end

`ifdef ETH_MDIO_IRQ_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (wr && address == 2'd3) irq_en <= writedata[2];
            irq <= done & irq_en;
        end
    end
`else
    assign irq_en = 1'b0;
    assign irq    = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd1:    readdata[15:0] = wdata;
            2'd2:    readdata[15:0] = rdata;
            2'd3:    readdata[2:0]  = {irq_en, done, busy};
            default: readdata       = '0;
        endcase
    end

endmodule

// File: tb/tb_eth_mdio_master.sv
// Randomized scoreboard bench for eth_mdio_master: serial stream checked by a monitor, registers by the stimulus.
module tb_eth_mdio_master;
    localparam int CLK_DIV = 2;
    localparam int PRE_LEN = 32;
    localparam int NB      = PRE_LEN + 32;
    localparam int FLEN    = NB * 2 * CLK_DIV;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        mdc, mdio_o, mdio_oe, irq;
    logic        mdio_i = 1'b1;

    eth_mdio_master #(.CLK_DIV(CLK_DIV), .PRE_LEN(PRE_LEN)) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata), .mdc(mdc),
        .mdio_o(mdio_o), .mdio_oe(mdio_oe), .mdio_i(mdio_i), .irq(irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        op;
        logic [4:0]  phyad;
        logic [4:0]  regad;
        logic [15:0] wdata;
        logic [15:0] rdval;
    } frame_t;

    frame_t      exp_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          frames_seen = 0;
    int          frames_run = 0;
    logic [15:0] m_wdata = '0;
    logic [15:0] m_rdata = '0;
    logic        m_irq_en = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    function automatic frame_t mk(input logic op, input logic [4:0] ph, input logic [4:0] rg,
                                  input logic [15:0] wd, input logic [15:0] rv);
        frame_t f;
        f.op = op; f.phyad = ph; f.regad = rg; f.wdata = wd; f.rdval = rv;
        return f;
    endfunction

    // PHY response for the bit about to start: TA second bit 0, then read data MSB first
    function automatic logic phy_bit(input frame_t f, input int idx);
        int d;
        d = idx - (PRE_LEN + 16);
        if (!f.op) return 1'b1;
        if (idx == PRE_LEN + 15) return 1'b0;
        if (d >= 0 && d < 16) return f.rdval[15 - d];
        return 1'b1;
    endfunction

    logic          prev_mdc = 1'b0, prev_oe = 1'b0, in_frame = 1'b0, irq_seen = 1'b0;
    int            rc = 0;
    logic [NB-1:0] got_o, got_oe, exp_o, exp_oe;
    frame_t        cur;

    initial begin : monitor
        forever begin
            @(negedge clk);
            if (irq !== 1'b0) irq_seen = 1'b1;
            if (!reset_n) begin
                in_frame = 1'b0;
                rc = 0;
                mdio_i = 1'b1;
            end else begin
                if (mdio_oe && !prev_oe && !in_frame) begin
                    rc = 0; got_o = '0; got_oe = '0; mdio_i = 1'b1;
                    if (exp_q.size() > 0) begin
                        cur = exp_q[0];
                        in_frame = 1'b1;
                    end else begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_frame: got frame start expected none");
                    end
                end
                if (in_frame && mdc && !prev_mdc) begin
                    got_o[NB-1-rc]  = mdio_o;
                    got_oe[NB-1-rc] = mdio_oe;
                    rc++;
                    if (rc == NB) begin
                        exp_o  = {{PRE_LEN{1'b1}}, 2'b01, (cur.op ? 2'b10 : 2'b01), cur.phyad, cur.regad,
                                  2'b10, (cur.op ? 16'h0000 : cur.wdata)};
                        exp_oe = cur.op ? {{(PRE_LEN+14){1'b1}}, 18'b0} : '1;
                        check("mdio_stream", 64'(got_o & exp_oe), 64'(exp_o & exp_oe));
                        check("mdio_oe_pattern", 64'(got_oe), 64'(exp_oe));
                        void'(exp_q.pop_front());
                        in_frame = 1'b0;
                        frames_seen++;
                    end
                end
                if (in_frame && !mdc && prev_mdc) mdio_i = phy_bit(cur, rc);
            end
            prev_mdc = mdc;
            prev_oe  = mdio_oe;
        end
    end

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; address = 2'd3;
    endtask

    task automatic bus_read_check(input string name, input logic [1:0] a, input logic [31:0] e);
        @(negedge clk);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1 check(name, 64'(readdata), 64'(e));
    endtask

    // mode 0 plain, 1 second start + WDATA rewrite mid-frame, 2 done clear on completion edge, 3 reset in PHYAD
    task automatic run_frame(input frame_t f, input int mode);
        int   k;
        logic busy_now;
        bus_write(2'd1, {16'h0, f.wdata});
        m_wdata = f.wdata;
        exp_q.push_back(f);
        bus_write(2'd0, {20'h0, 1'b1, f.op, f.phyad, f.regad});
        k = 1;
        forever begin
            chipselect = 1'b1; write_n = 1'b1; address = 2'd3;
            if (mode == 1 && k == 10) begin
                address = 2'd0; write_n = 1'b0;
                writedata = {20'h0, 1'b1, ~f.op, ~f.phyad, ~f.regad};
            end
            if (mode == 1 && k == 50) begin
                address = 2'd1; write_n = 1'b0; writedata = $urandom;
                m_wdata = writedata[15:0];
            end
            if (mode == 2 && k == FLEN) begin
                write_n = 1'b0; writedata = {29'h0, m_irq_en, 2'b10};
            end
            if (mode == 3 && k == 150) begin
                reset_n = 1'b0;
                #1 check("reset_pins", 64'({mdc, mdio_oe, mdio_o, irq}), 64'(4'b0010));
                address = 2'd2;
                #1 check("reset_rdata", 64'(readdata), 64'd0);
                address = 2'd3;
                #1 check("reset_status", 64'(readdata), 64'd0);
                chipselect = 1'b0;
                repeat (2) @(negedge clk);
                reset_n = 1'b1;
                void'(exp_q.pop_front());
                m_rdata = '0; m_wdata = '0; m_irq_en = 1'b0;
                return;
            end
            #1;
            busy_now = (address == 2'd3) ? readdata[0] : 1'b1;
            if (!busy_now) break;
            if (k > FLEN + 20) begin
                $display("FAIL busy_timeout: got busy after %0d cycles expected idle", k);
                break;
            end
            k++;
            @(negedge clk);
        end
        frames_run++;
        chipselect = 1'b1; write_n = 1'b1; address = 2'd3;
        #1;
        check("busy_cycles", 64'(k - 1), 64'(FLEN));
        check("idle_pins", 64'({mdc, mdio_oe, mdio_o}), 64'(3'b001));
        check("status_done", 64'(readdata), 64'({m_irq_en, 2'b10}));
        check("irq_first_done_cycle", 64'(irq), 64'd0);
        @(negedge clk);
        #1 check("irq_after_done", 64'(irq), 64'(m_irq_en));
        if (f.op) m_rdata = f.rdval;
        bus_read_check("rdata", 2'd2, {16'h0, m_rdata});
        bus_read_check("wdata", 2'd1, {16'h0, m_wdata});
        bus_write(2'd3, {29'h0, m_irq_en, 2'b10});
        #1 check("status_cleared", 64'(readdata), 64'({m_irq_en, 2'b00}));
        check("irq_hold_after_clear", 64'(irq), 64'(m_irq_en));
        @(negedge clk);
        #1 check("irq_off_after_clear", 64'(irq), 64'd0);
    endtask

    initial begin : stimulus
        frame_t f;
        repeat (3) @(negedge clk);
        chipselect = 1'b1;
        #1 check("reset_outputs", 64'({mdc, mdio_o, mdio_oe, irq}), 64'(4'b0100));
        bus_read_check("reset_status", 2'd3, 32'h0);
        bus_read_check("reset_rdata", 2'd2, 32'h0);
        bus_read_check("reset_wdata", 2'd1, 32'h0);
        bus_read_check("cmd_reads_zero", 2'd0, 32'h0);
        reset_n = 1'b1;

        run_frame(mk(1'b0, 5'd1, 5'd0, 16'h1140, 16'h0), 0);
        run_frame(mk(1'b1, 5'h1f, 5'd2, 16'h0, 16'h0022), 0);

`ifdef ETH_MDIO_IRQ_EN
        m_irq_en = 1'b1;
`endif
        bus_write(2'd3, 32'h4);
        #1 check("irq_en_readback", 64'(readdata), 64'({m_irq_en, 2'b00}));

        f = mk(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
        run_frame(f, 1);
        repeat (20) @(negedge clk);
        #1 check("no_second_frame", 64'(readdata[0]), 64'd0);
        f = mk(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
        run_frame(f, 2);

        for (int i = 0; i < 6; i++) begin
            f = mk(1'($urandom), 5'($urandom), 5'($urandom), 16'($urandom), 16'($urandom));
            run_frame(f, 0);
        end

        run_frame(mk(1'b1, 5'd3, 5'd1, 16'h0, 16'hA5C3), 0);
        run_frame(mk(1'b1, 5'($urandom), 5'($urandom), 16'h0, 16'($urandom)), 3);
        run_frame(mk(1'b0, 5'($urandom), 5'($urandom), 16'($urandom), 16'h0), 0);
        run_frame(mk(1'b1, 5'($urandom), 5'($urandom), 16'h0, 16'($urandom)), 0);

        repeat (10) @(negedge clk);
        check("frames_completed", 64'(frames_seen), 64'(frames_run));
        check("queue_drained", 64'(exp_q.size()), 64'd0);
`ifndef ETH_MDIO_IRQ_EN
        check("irq_never_set", 64'(irq_seen), 64'd0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
